// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel registered mux with fixed or round-robin select and valid/ready handshake
module rr_mux_n #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   output logic [N_CH-1:0]          in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   // Channel count padded to the full select range so an out-of-range
   // index reads a zero valid bit instead of falling off the vector.
   localparam int N_PAD = 1 << SEL_W;
   localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

   logic [SEL_W-1:0]  last_grant;
   logic [N_PAD-1:0]  valid_pad;
   logic [SEL_W:0]    rr_pos;
   logic [SEL_W-1:0]  rr_idx;
   logic              rr_found;
   logic              sel_ok;
   logic              fix_found;
   logic [SEL_W-1:0]  cand;
   logic              cand_found;
   logic              can_load;
   logic              grant;
   logic [DATA_W-1:0] cand_data;

   // Zero-extend the valid vector to the padded width.
   always_comb begin
      valid_pad = '0;
      valid_pad[N_CH-1:0] = in_valid;
   end

   // Round-robin search: first valid channel after last_grant, wrapping at N_CH.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_pos   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         rr_pos = {1'b0, last_grant} + (SEL_W+1)'(k);
         if (rr_pos >= N_CH_W)
            rr_pos = rr_pos - N_CH_W;
         if (!rr_found && valid_pad[rr_pos[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = rr_pos[SEL_W-1:0];
         end
      end
   end

   // Candidate choice and grant decision; nothing is granted while in reset.
   always_comb begin
      sel_ok     = ({1'b0, sel} < N_CH_W);
      fix_found  = sel_ok && valid_pad[sel];
      cand       = mode ? rr_idx   : sel;
      cand_found = mode ? rr_found : fix_found;
      can_load   = !out_valid || out_ready;
      grant      = rst_n && can_load && cand_found;
   end

   // One-hot ready to the granted channel and data mux for the candidate.
   always_comb begin
      in_ready  = '0;
      cand_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (SEL_W'(i) == cand) begin
            in_ready[i] = grant;
            cand_data   = in_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output register: load on grant, clear valid on a drain with no grant, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         last_grant <= SEL_W'(N_CH - 1);
      end else if (grant) begin
         out_valid  <= 1'b1;
         out_data   <= cand_data;
         out_ch     <= cand;
         last_grant <= cand;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb/tb_rr_mux_n.sv - directed table-driven bench for rr_mux_n
module tb_rr_mux_n;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;

   logic        mode3;
   logic [1:0]  sel3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_ready3;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic [3:0] valid;
      logic       ready;
      logic [3:0] exp_ir;
      logic       exp_ov;
      logic [7:0] exp_d;
      logic [1:0] exp_ch;
   } vec_t;

   vec_t vecs [20];

   rr_mux_n #(.N_CH(4), .DATA_W(8)) u4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
      .out_ready(out_ready)
   );

   rr_mux_n #(.N_CH(3), .DATA_W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
      .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
      .out_ready(out_ready3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      in_data3 = {8'h33, 8'h22, 8'h11};
      mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b0;

      vecs[0]  = '{1'b0, 2'd0, 4'hf, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vecs[1]  = '{1'b0, 2'd1, 4'hf, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[2]  = '{1'b0, 2'd2, 4'hf, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      vecs[3]  = '{1'b0, 2'd3, 4'hf, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[4]  = '{1'b0, 2'd2, 4'hf, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      vecs[5]  = '{1'b1, 2'd2, 4'hf, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[6]  = '{1'b1, 2'd2, 4'hf, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
      vecs[7]  = '{1'b1, 2'd0, 4'hf, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[8]  = '{1'b1, 2'd0, 4'hf, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      vecs[9]  = '{1'b1, 2'd0, 4'hf, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[10] = '{1'b1, 2'd0, 4'ha, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[11] = '{1'b1, 2'd0, 4'ha, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
      vecs[12] = '{1'b1, 2'd0, 4'ha, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
      vecs[13] = '{1'b1, 2'd0, 4'hf, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[14] = '{1'b1, 2'd0, 4'hf, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[15] = '{1'b1, 2'd0, 4'hf, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
      vecs[16] = '{1'b1, 2'd0, 4'hf, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
      vecs[17] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};
      vecs[18] = '{1'b0, 2'd1, 4'h0, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2};
      vecs[19] = '{1'b0, 2'd0, 4'he, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};

      // reset state, with requests already present
      rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hf; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // RR fairness straight out of reset
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
         cyc();
         chk($sformatf("rr%0d_out_ch", i), 32'(out_ch), 32'(i % 4));
         chk($sformatf("rr%0d_out_data", i), 32'(out_data), 32'(8'h11 * ((i % 4) + 1)));
      end

      // table: fixed mode, mode switch, RR subset, backpressure, drain
      for (int v = 0; v < 20; v++) begin
         mode = vecs[v].mode; sel = vecs[v].sel;
         in_valid = vecs[v].valid; out_ready = vecs[v].ready;
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_ir));
         cyc();
         chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_ov));
         chk($sformatf("v%0d_out_data", v),  32'(out_data),  32'(vecs[v].exp_d));
         chk($sformatf("v%0d_out_ch", v),    32'(out_ch),    32'(vecs[v].exp_ch));
      end

      // async reset mid-stream
      mode = 1'b1; in_valid = 4'hf; out_ready = 1'b1;
      cyc();
      chk("ar_load_ch", 32'(out_ch), 32'd3);
      chk("ar_load_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_out_data",  32'(out_data),  32'd0);
      chk("ar_out_ch",    32'(out_ch),    32'd0);
      chk("ar_in_ready",  32'(in_ready),  32'd0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("ar_post_in_ready", 32'(in_ready), 32'b0001);
      cyc();
      chk("ar_post_out_ch", 32'(out_ch), 32'd0);
      chk("ar_post_out_data", 32'(out_data), 32'h11);
      chk("ar_post_out_valid", 32'(out_valid), 32'd1);

      // N_CH=3: out-of-range select never grants
      mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
      @(negedge clk);
      chk("n3_load_in_ready", 32'(in_ready3), 32'b010);
      cyc();
      chk("n3_load_valid", 32'(out_valid3), 32'd1);
      chk("n3_load_data", 32'(out_data3), 32'h22);
      sel3 = 2'd3; out_ready3 = 1'b0;
      @(negedge clk);
      chk("n3_oor_hold_in_ready", 32'(in_ready3), 32'b000);
      cyc();
      chk("n3_oor_hold_valid", 32'(out_valid3), 32'd1);
      out_ready3 = 1'b1;
      @(negedge clk);
      chk("n3_oor_drain_in_ready", 32'(in_ready3), 32'b000);
      cyc();
      chk("n3_oor_drain_valid", 32'(out_valid3), 32'd0);
      chk("n3_oor_drain_ch", 32'(out_ch3), 32'd1);
      sel3 = 2'd2;
      @(negedge clk);
      chk("n3_top_in_ready", 32'(in_ready3), 32'b100);
      cyc();
      chk("n3_top_data", 32'(out_data3), 32'h33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
